// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative radix-2 multiply/divide unit for the EX stage.
//
// Operations: MUL (low word), MULH (high word), DIV (quotient) and REM
// (remainder). Each is available signed or unsigned. The core works on
// operand magnitudes for WORD_WIDTH cycles. One FIX cycle then applies the
// sign and the divide-by-zero rules. A one-cycle DONE state carries the
// result strobe.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   in_start        request a new operation this cycle
//   in_op           00 MUL, 01 MULH, 10 DIV, 11 REM
//   in_signed       1 = two's-complement operands
//   in_src1         multiplicand / dividend
//   in_src2         multiplier / divisor
//   in_res_reg_idx  destination register index, returned with the result
//   in_flush        abort the operation in flight or the one requested
//   out_busy        stall request (combinational, covers the issue cycle)
//   out_res_valid   one-cycle result strobe
//   out_res         result word, held until the next FIX
//   out_res_reg_idx destination register of out_res
module exec_muldiv #(
  parameter int WORD_WIDTH    = 16,
  parameter int REG_IDX_WIDTH = 4,
  parameter int CNT_WIDTH     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_start,
  input  logic [1:0]               in_op,
  input  logic                     in_signed,
  input  logic [WORD_WIDTH-1:0]    in_src1,
  input  logic [WORD_WIDTH-1:0]    in_src2,
  input  logic [REG_IDX_WIDTH-1:0] in_res_reg_idx,
  input  logic                     in_flush,
  output logic                     out_busy,
  output logic                     out_res_valid,
  output logic [WORD_WIDTH-1:0]    out_res,
  output logic [REG_IDX_WIDTH-1:0] out_res_reg_idx
);

  localparam int W = WORD_WIDTH;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                   state_q,   state_d;
  logic [CNT_WIDTH-1:0]     cnt_q,     cnt_d;
  logic [1:0]               op_q,      op_d;
  logic                     sgn_q,     sgn_d;
  logic                     neg_q,     neg_d;
  logic                     dvz_q,     dvz_d;
  logic [REG_IDX_WIDTH-1:0] idx_q,     idx_d;
  logic [W-1:0]             mag1_q,    mag1_d;
  logic [W-1:0]             mag2_q,    mag2_d;
  logic [W-1:0]             src1_q,    src1_d;
  logic [2*W-1:0]           acc_q,     acc_d;
  logic [W-1:0]             res_q,     res_d;
  logic [REG_IDX_WIDTH-1:0] res_idx_q, res_idx_d;

  logic accept;

  // Magnitude of an operand. Unsigned operands pass through unchanged.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic s);
    magnitude = (s && v[W-1]) ? -v : v;
  endfunction

  // One shift-add step. acc holds {partial product, remaining multiplier bits}.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc,
                                               input logic [W-1:0]   m);
    logic [W:0] sum;
    sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : {(W+1){1'b0}});
    mul_step = {sum, acc[W-1:1]};
  endfunction

  // One restoring-division step. acc holds {remainder, dividend/quotient bits}.
  function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] acc,
                                               input logic [W-1:0]   d);
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {acc[2*W-1:W], acc[W-1]};
    diff = sh - {1'b0, d};
    if (!diff[W]) div_step = {diff[W-1:0], acc[W-2:0], 1'b1};
    else          div_step = {sh[W-1:0],   acc[W-2:0], 1'b0};
  endfunction

  // Sign correction and result selection. Divide-by-zero bypasses the sign fix.
  function automatic logic [W-1:0] fix_result(input logic [1:0]     op,
                                               input logic           neg,
                                               input logic           dvz,
                                               input logic [2*W-1:0] acc,
                                               input logic [W-1:0]   src1);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[W-1:0] : acc[W-1:0];
    rem  = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      OP_MUL:  fix_result = prod[W-1:0];
      OP_MULH: fix_result = prod[2*W-1:W];
      OP_DIV:  fix_result = dvz ? {W{1'b1}} : quo;
      default: fix_result = dvz ? src1 : rem;
    endcase
  endfunction

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && in_start && !in_flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    dvz_d     = dvz_q;
    idx_d     = idx_q;
    mag1_d    = mag1_q;
    mag2_d    = mag2_q;
    src1_d    = src1_q;
    acc_d     = acc_q;
    res_d     = res_q;
    res_idx_d = res_idx_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = in_op;
          sgn_d   = in_signed;
          idx_d   = in_res_reg_idx;
          mag1_d  = magnitude(in_src1, in_signed);
          mag2_d  = magnitude(in_src2, in_signed);
          src1_d  = in_src1;
          dvz_d   = (in_src2 == '0);
          neg_d   = in_signed & ((in_op == OP_REM) ? in_src1[W-1]
                                                   : (in_src1[W-1] ^ in_src2[W-1]));
          // Multiply seeds the low half with the multiplier, divide with the dividend.
          acc_d   = in_op[1] ? {{W{1'b0}}, magnitude(in_src1, in_signed)}
                             : {{W{1'b0}}, magnitude(in_src2, in_signed)};
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        acc_d = op_q[1] ? div_step(acc_q, mag2_q) : mul_step(acc_q, mag1_q);
        if (cnt_q == CNT_WIDTH'(W - 1)) state_d = FIX;
      end
      FIX: begin
        res_d     = fix_result(op_q, neg_q & sgn_q, dvz_q, acc_q, src1_q);
        res_idx_d = idx_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A flush beats everything, including a flush landing in FIX.
    if (in_flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      res_d     = res_q;
      res_idx_d = res_idx_q;
    end
  end

  // ---- state / datapath register boundary ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      dvz_q     <= 1'b0;
      idx_q     <= '0;
      mag1_q    <= '0;
      mag2_q    <= '0;
      src1_q    <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      dvz_q     <= dvz_d;
      idx_q     <= idx_d;
      mag1_q    <= mag1_d;
      mag2_q    <= mag2_d;
      src1_q    <= src1_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_idx_q <= res_idx_d;
    end
  end

  assign out_busy        = (state_q == CALC) || (state_q == FIX) || accept;
  assign out_res_valid   = (state_q == DONE);
  assign out_res         = res_q;
  assign out_res_reg_idx = res_idx_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed testbench for exec_muldiv (WORD_WIDTH=16).
module tb_exec_muldiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_start = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic        in_signed = 1'b0;
  logic [15:0] in_src1 = '0;
  logic [15:0] in_src2 = '0;
  logic [3:0]  in_res_reg_idx = '0;
  logic        in_flush = 1'b0;
  logic        out_busy;
  logic        out_res_valid;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;

  int total = 0;
  int bad   = 0;

  exec_muldiv #(.WORD_WIDTH(16), .REG_IDX_WIDTH(4), .CNT_WIDTH(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_start       (in_start),
    .in_op          (in_op),
    .in_signed      (in_signed),
    .in_src1        (in_src1),
    .in_src2        (in_src2),
    .in_res_reg_idx (in_res_reg_idx),
    .in_flush       (in_flush),
    .out_busy       (out_busy),
    .out_res_valid  (out_res_valid),
    .out_res        (out_res),
    .out_res_reg_idx(out_res_reg_idx)
  );

  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic sgn, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] idx);
    in_start = 1'b1; in_op = op; in_signed = sgn;
    in_src1 = a; in_src2 = b; in_res_reg_idx = idx;
  endtask

  // Counts edges until out_res_valid is seen; lat = -1 if the budget expires.
  task automatic wait_valid(output int lat, output logic [15:0] r, output logic [3:0] ri);
    bit found;
    found = 1'b0; lat = 0; r = '0; ri = '0;
    while (!found && lat < 40) begin
      cycle();
      in_start = 1'b0;
      lat++;
      if (out_res_valid) begin
        found = 1'b1; r = out_res; ri = out_res_reg_idx;
      end
    end
    if (!found) lat = -1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    total++; if (out_res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_res_valid); end
    total++; if (out_res !== 16'h0000) begin bad++; $display("FAIL reset_res got=%h exp=0000", out_res); end
    total++; if (out_res_reg_idx !== 4'h0) begin bad++; $display("FAIL reset_idx got=%h exp=0", out_res_reg_idx); end
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    total++; if (out_busy !== 1'b0 || out_res_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b%b exp=00", out_busy, out_res_valid); end
  endtask

  task automatic test_mul_unsigned();
    int lat, bcnt;
    bit done;
    drive(2'b00, 1'b0, 16'd300, 16'd200, 4'd5);
    #1;
    bcnt = out_busy ? 1 : 0;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      cycle();
      in_start = 1'b0;
      lat++;
      if (out_res_valid) done = 1'b1;
      else if (out_busy) bcnt++;
    end
    total++; if (lat !== 18) begin bad++; $display("FAIL mul_u_latency got=%0d exp=18", lat); end
    total++; if (bcnt !== 18) begin bad++; $display("FAIL mul_u_busy_cycles got=%0d exp=18", bcnt); end
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL mul_u_busy_in_done got=%b exp=0", out_busy); end
    total++; if (out_res !== 16'hEA60) begin bad++; $display("FAIL mul_u_res got=%h exp=EA60", out_res); end
    total++; if (out_res_reg_idx !== 4'd5) begin bad++; $display("FAIL mul_u_idx got=%0d exp=5", out_res_reg_idx); end
    cycle();
    total++; if (out_res_valid !== 1'b0) begin bad++; $display("FAIL mul_u_pulse_width got=%b exp=0", out_res_valid); end
    total++; if (out_res !== 16'hEA60) begin bad++; $display("FAIL mul_u_hold got=%h exp=EA60", out_res); end
  endtask

  task automatic test_arith();
    logic [1:0]  op_t  [9];
    logic        sg_t  [9];
    logic [15:0] a_t   [9];
    logic [15:0] b_t   [9];
    logic [15:0] exp_t [9];
    int lat;
    logic [15:0] r;
    logic [3:0]  ri;
    op_t  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11};
    sg_t  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    a_t   = '{16'hFFFD, 16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFF9, 16'hFFF9, 16'd123, 16'd1000, 16'd1000};
    b_t   = '{16'd5, 16'd5, 16'hFFFF, 16'd2, 16'd2, 16'd2, 16'd45, 16'd7, 16'd7};
    exp_t = '{16'hFFF1, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFF, 16'h7FFC, 16'h159F, 16'h008E, 16'h0006};
    for (int i = 0; i < 9; i++) begin
      drive(op_t[i], sg_t[i], a_t[i], b_t[i], 4'(i + 1));
      wait_valid(lat, r, ri);
      total++; if (r !== exp_t[i] || lat !== 18) begin bad++; $display("FAIL arith_%0d got=%h lat=%0d exp=%h lat=18", i, r, lat, exp_t[i]); end
      total++; if (ri !== 4'(i + 1)) begin bad++; $display("FAIL arith_idx_%0d got=%0d exp=%0d", i, ri, i + 1); end
      cycle();
    end
  endtask

  task automatic test_boundaries();
    logic [1:0]  op_t  [8];
    logic        sg_t  [8];
    logic [15:0] a_t   [8];
    logic [15:0] b_t   [8];
    logic [15:0] exp_t [8];
    int lat;
    logic [15:0] r;
    logic [3:0]  ri;
    op_t  = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    sg_t  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    a_t   = '{16'd100, 16'd100, 16'h8000, 16'h8000, 16'hFFFB, 16'hFFFB, 16'd0, 16'd0};
    b_t   = '{16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd7, 16'd7};
    exp_t = '{16'hFFFF, 16'h0064, 16'h8000, 16'h0000, 16'hFFFF, 16'hFFFB, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      drive(op_t[i], sg_t[i], a_t[i], b_t[i], 4'(i + 8));
      wait_valid(lat, r, ri);
      total++; if (r !== exp_t[i] || lat !== 18) begin bad++; $display("FAIL bound_%0d got=%h lat=%0d exp=%h lat=18", i, r, lat, exp_t[i]); end
      cycle();
    end
  endtask

  task automatic test_flush();
    int lat, vcnt;
    logic [15:0] r;
    logic [3:0]  ri;
    drive(2'b00, 1'b0, 16'd3, 16'd4, 4'd2);
    wait_valid(lat, r, ri);
    total++; if (r !== 16'h000C) begin bad++; $display("FAIL flush_pre_res got=%h exp=000C", r); end
    cycle();
    drive(2'b00, 1'b0, 16'd10, 16'd10, 4'd3);
    cycle();
    in_start = 1'b0;
    repeat (4) cycle();
    in_flush = 1'b1;
    cycle();
    in_flush = 1'b0;
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", out_busy); end
    vcnt = 0;
    repeat (20) begin if (out_res_valid) vcnt++; cycle(); end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL flush_no_pulse got=%0d exp=0", vcnt); end
    total++; if (out_res !== 16'h000C || out_res_reg_idx !== 4'd2) begin bad++; $display("FAIL flush_res_hold got=%h/%0d exp=000C/2", out_res, out_res_reg_idx); end
    drive(2'b00, 1'b0, 16'd7, 16'd6, 4'd6);
    wait_valid(lat, r, ri);
    total++; if (r !== 16'h002A || ri !== 4'd6 || lat !== 18) begin bad++; $display("FAIL flush_restart got=%h/%0d lat=%0d exp=002A/6 lat=18", r, ri, lat); end
    cycle();
    drive(2'b10, 1'b0, 16'd50, 16'd5, 4'd4);
    in_flush = 1'b1;
    #1;
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b exp=0", out_busy); end
    cycle();
    in_start = 1'b0; in_flush = 1'b0;
    #1;
    total++; if (out_busy !== 1'b0) begin bad++; $display("FAIL flush_start_nostart got=%b exp=0", out_busy); end
    vcnt = 0;
    repeat (20) begin if (out_res_valid) vcnt++; cycle(); end
    total++; if (vcnt !== 0 || out_res !== 16'h002A) begin bad++; $display("FAIL flush_start_quiet got=%0d/%h exp=0/002A", vcnt, out_res); end
  endtask

  task automatic test_back_to_back();
    int lat, n, vcnt;
    logic [15:0] r;
    logic [3:0]  ri;
    drive(2'b10, 1'b0, 16'd1000, 16'd7, 4'd1);
    wait_valid(lat, r, ri);
    total++; if (r !== 16'h008E || ri !== 4'd1) begin bad++; $display("FAIL b2b_first got=%h/%0d exp=008E/1", r, ri); end
    drive(2'b11, 1'b0, 16'd1000, 16'd7, 4'd2);
    #1;
    total++; if (out_busy !== 1'b1) begin bad++; $display("FAIL b2b_done_accept got=%b exp=1", out_busy); end
    wait_valid(lat, r, ri);
    total++; if (r !== 16'h0006 || ri !== 4'd2 || lat !== 18) begin bad++; $display("FAIL b2b_second got=%h/%0d lat=%0d exp=0006/2 lat=18", r, ri, lat); end
    cycle();
    cycle();
    drive(2'b00, 1'b0, 16'd123, 16'd45, 4'd7);
    cycle();
    in_start = 1'b0;
    cycle();
    drive(2'b10, 1'b0, 16'd9, 16'd3, 4'd8);
    cycle();
    in_start = 1'b0;
    n = 3;
    wait_valid(lat, r, ri);
    total++; if (r !== 16'h159F || ri !== 4'd7 || n + lat !== 18) begin bad++; $display("FAIL midcalc_ignore got=%h/%0d lat=%0d exp=159F/7 lat=18", r, ri, n + lat); end
    vcnt = 0;
    repeat (22) begin cycle(); if (out_res_valid) vcnt++; end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL midcalc_no_second got=%0d exp=0", vcnt); end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    drive(2'b00, 1'b0, 16'd2, 16'd3, 4'd9);
    cycle();
    in_start = 1'b0;
    repeat (5) cycle();
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_busy !== 1'b0 || out_res_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got=%b%b exp=00", out_busy, out_res_valid); end
    total++; if (out_res !== 16'h0000 || out_res_reg_idx !== 4'd0) begin bad++; $display("FAIL rst_mid_res got=%h/%0d exp=0000/0", out_res, out_res_reg_idx); end
    cycle();
    reset = 1'b0;
    vcnt = 0;
    repeat (25) begin cycle(); if (out_res_valid || out_busy) vcnt++; end
    total++; if (vcnt !== 0) begin bad++; $display("FAIL rst_mid_no_pulse got=%0d exp=0", vcnt); end
  endtask

  initial begin
    test_reset();
    test_mul_unsigned();
    test_arith();
    test_boundaries();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
